// File: rtl/spi_slave_fd.sv
// Full-duplex SPI slave: oversampled SCK/MOSI/CSn, any CPOL/CPHA, selectable bit order.
// RX words leave on a valid/ready port; TX words come from a one-deep holding register.
module spi_slave_fd #(
   parameter int DATA_W      = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_spi_s_sck,
   input  logic              i_spi_s_mosi,
   input  logic              i_spi_s_cs_n,
   output logic              o_spi_s_miso,
   output logic              o_spi_s_miso_oe,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   input  logic              i_rx_ready,
   output logic              o_rx_overrun,
   output logic              o_tx_underrun,
   output logic              o_busy
);

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic             SCK_IDLE = (CPOL != 0);

   typedef enum logic {IDLE, XFER} state_t;
   state_t state_reg, state_next;

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
   logic                   sck_prev;
   logic                   sck_s, mosi_s, cs_s;
   logic                   rise, fall, leading_edge, trailing_edge, sample_edge, shift_edge;

   logic [DATA_W-1:0] tx_shift_reg, hold_data_reg, rx_shift_reg, rx_data_reg;
   logic [DATA_W-1:0] tx_shifted, rx_shifted, tx_load_val;
   logic [CNT_W-1:0]  bit_cnt_reg;
   logic              hold_full_reg, skip_reg, under_pend_reg, word_done_reg;
   logic              rx_valid_reg, rx_overrun_reg, tx_underrun_reg;
   logic              load_tx, word_end, miso_bit, in_xfer;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_prev  <= SCK_IDLE;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_s_sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_s_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_s_mosi};
         sck_prev  <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s         = sck_sync[SYNC_STAGES-1];
   assign cs_s          = cs_sync[SYNC_STAGES-1];
   assign mosi_s        = mosi_sync[SYNC_STAGES-1];
   assign rise          = sck_s & ~sck_prev;
   assign fall          = ~sck_s & sck_prev;
   assign leading_edge  = SCK_IDLE ? fall : rise;
   assign trailing_edge = SCK_IDLE ? rise : fall;
   assign sample_edge   = (CPHA != 0) ? trailing_edge : leading_edge;
   assign shift_edge    = (CPHA != 0) ? leading_edge : trailing_edge;
   assign in_xfer       = (state_reg == XFER) && !cs_s;

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign tx_shifted = {tx_shift_reg[DATA_W-2:0], 1'b0};
         assign rx_shifted = {rx_shift_reg[DATA_W-2:0], mosi_s};
         assign miso_bit   = tx_shift_reg[DATA_W-1];
      end else begin : g_lsb_first
         assign tx_shifted = {1'b0, tx_shift_reg[DATA_W-1:1]};
         assign rx_shifted = {mosi_s, rx_shift_reg[DATA_W-1:1]};
         assign miso_bit   = tx_shift_reg[0];
      end
   endgenerate

   assign tx_load_val = hold_full_reg ? hold_data_reg : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      load_tx    = 1'b0;
      word_end   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!cs_s) begin
               load_tx    = 1'b1;
               state_next = XFER;
            end
         end
         XFER: begin
            if (cs_s) begin
               state_next = IDLE;
            end else if (sample_edge && bit_cnt_reg == LAST_BIT) begin
               word_end = 1'b1;
               load_tx  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_data_reg   <= '0;
         hold_full_reg   <= 1'b0;
         tx_shift_reg    <= '0;
         skip_reg        <= 1'b0;
         under_pend_reg  <= 1'b0;
         tx_underrun_reg <= 1'b0;
      end else begin
         tx_underrun_reg <= 1'b0;
         if (i_tx_valid && !hold_full_reg) begin
            hold_data_reg <= i_tx_data;
            hold_full_reg <= 1'b1;
         end else if (load_tx) begin
            hold_full_reg <= 1'b0;
         end
         // A reload after the last bit must not be shifted away by the edge that still follows it.
         if (load_tx) begin
            tx_shift_reg <= tx_load_val;
            skip_reg     <= (CPHA != 0) || (state_reg == XFER);
         end else if (in_xfer && shift_edge) begin
            if (skip_reg) skip_reg <= 1'b0;
            else          tx_shift_reg <= tx_shifted;
         end
         // An empty reload only counts as underrun once the next word actually starts.
         if (load_tx && !hold_full_reg) begin
            if (state_reg == IDLE) tx_underrun_reg <= 1'b1;
            else                   under_pend_reg  <= 1'b1;
         end else if (cs_s) begin
            under_pend_reg <= 1'b0;
         end else if (under_pend_reg && leading_edge && state_reg == XFER) begin
            tx_underrun_reg <= 1'b1;
            under_pend_reg  <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_shift_reg   <= '0;
         bit_cnt_reg    <= '0;
         word_done_reg  <= 1'b0;
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         rx_overrun_reg <= 1'b0;
      end else begin
         word_done_reg  <= word_end;
         rx_overrun_reg <= 1'b0;
         if (in_xfer && sample_edge) begin
            rx_shift_reg <= rx_shifted;
            bit_cnt_reg  <= word_end ? '0 : bit_cnt_reg + CNT_W'(1);
         end else if (cs_s || state_reg == IDLE) begin
            bit_cnt_reg <= '0;
         end
         if (word_done_reg) begin
            rx_data_reg    <= rx_shift_reg;
            rx_valid_reg   <= 1'b1;
            rx_overrun_reg <= rx_valid_reg && !i_rx_ready;
         end else if (rx_valid_reg && i_rx_ready) begin
            rx_valid_reg <= 1'b0;
         end
      end
   end

   assign o_spi_s_miso_oe = ~cs_s;
   assign o_spi_s_miso    = ~cs_s & miso_bit;
   assign o_busy          = ~cs_s;
   assign o_tx_ready      = ~hold_full_reg;
   assign o_rx_data       = rx_data_reg;
   assign o_rx_valid      = rx_valid_reg;
   assign o_rx_overrun    = rx_overrun_reg;
   assign o_tx_underrun   = tx_underrun_reg;

endmodule

// File: doc/spi_slave_fd.md
Name: spi_slave_fd

Overview:
Parametrised full-duplex SPI slave for the 50 MHz fabric clock.
- Supports all four SPI modes (CPOL/CPHA), configurable word width and bit order.
- Receives MOSI words into a valid/ready output port; transmits words from a one-deep TX holding register on MISO.
- Sits between the external SPI master pins and register/command logic; replaces the receive-only, mode-0-only slave.

Parameters:
- DATA_W, 8: bits per SPI word; legal range 4..32.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first; 0 = LSB first.
- SYNC_STAGES, 2: synchroniser flops for SCK/MOSI/CSn; legal range 2..3.

Ports:
- i_clk  in  1  fabric clock, 50 MHz
- i_rst_n  in  1  asynchronous active-low reset
- i_spi_s_sck  in  1  SPI clock from master
- i_spi_s_mosi  in  1  SPI data from master
- i_spi_s_cs_n  in  1  chip select, active low
- o_spi_s_miso  out  1  SPI data to master
- o_spi_s_miso_oe  out  1  MISO output enable
- i_tx_data  in  DATA_W  word to transmit
- i_tx_valid  in  1  TX word offered
- o_tx_ready  out  1  TX holding register empty
- o_rx_data  out  DATA_W  last received word
- o_rx_valid  out  1  o_rx_data valid, held until accepted
- i_rx_ready  in  1  consumer accepts o_rx_data
- o_rx_overrun  out  1  1-cycle pulse: an unaccepted word was overwritten
- o_tx_underrun  out  1  1-cycle pulse: word started with empty holding register
- o_busy  out  1  transfer in progress (synchronised CSn low)

Behaviour:
- Reset, asynchronous, active-low, clock i_clk:
  - All outputs 0, except o_tx_ready = 1.
  - Synchroniser SCK flops reset to CPOL; CSn flops reset to 1; MOSI flops reset to 0.
  - State = IDLE; holding register empty; shift registers 0.
- Synchronisation and edges:
  - SCK, MOSI and CSn each pass through SYNC_STAGES flops.
  - Edges are detected from the last two SCK stages.
  - Leading edge = rising if CPOL=0, falling if CPOL=1; trailing edge is the opposite.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- Host timing requirements:
  - SCK period >= 8 i_clk cycles.
  - CSn low to first SCK edge >= SYNC_STAGES+2 i_clk cycles.
  - Last SCK edge to CSn high >= 2 i_clk cycles.
- State machine:
  - IDLE: entered on synchronised CSn falling edge.
    - Loads the TX shift register from the holding register if full, marking the holding register empty.
    - Otherwise loads all-zeros and pulses o_tx_underrun.
    - Clears the bit counter; goes to XFER.
  - XFER:
    - On each sample edge, shift the MOSI bit into the RX shift register and increment the bit counter.
    - On each shift edge, advance the TX shift register.
    - For CPHA=1, the first shift edge (the leading edge of bit 0) presents bit 0 and does not advance.
    - When the counter reaches DATA_W on a sample edge:
      - Copy the RX shift register to o_rx_data on the next cycle.
      - Set o_rx_valid; if o_rx_valid was already 1 and not accepted that cycle, pulse o_rx_overrun (new data overwrites).
      - Reload the TX shift register from the holding register, or zeros plus an o_tx_underrun pulse.
      - Clear the counter; stay in XFER, so back-to-back words need no CSn toggle.
    - Synchronised CSn high from any state: go to IDLE.
      - Discard the partial RX word; no o_rx_valid.
      - The partially shifted TX word is lost; the holding register is untouched.
- MISO:
  - o_spi_s_miso = the current TX shift register bit (MSB or LSB per MSB_FIRST).
  - o_spi_s_miso_oe = 1 only while synchronised CSn is low; otherwise 0 and MISO = 0.
- TX handshake:
  - A word is accepted when i_tx_valid and o_tx_ready in the same cycle.
  - o_tx_ready falls the next cycle and rises the cycle after the holding register is consumed.
  - Load and consume in the same cycle: the consume takes the old content; the new word is stored and ready stays 0.
- RX handshake:
  - o_rx_valid clears the cycle after i_rx_ready is high while o_rx_valid is high.
  - Word completion in the same cycle as acceptance: valid stays 1 with new data; no overrun.
- Bit order: MSB_FIRST=0 reverses both the RX and TX shift directions.
- Receive latency: sample edge at the pin to o_rx_valid = SYNC_STAGES+2 i_clk cycles.

Test Plan:
- Mode 0, DATA_W=8, preload TX 0xA5, master sends 0x3C -> o_rx_data=0x3C, o_rx_valid=1; master reads 0xA5; o_tx_ready returns to 1 after CS fall.
- Modes 1/2/3 and MSB_FIRST=0, master sends 0x81 then 0x12 back-to-back in one CS -> two o_rx_valid words 0x81, 0x12 in order; MISO bits match mode timing.
- No TX preload, 2-word burst -> o_tx_underrun pulses twice; master reads 0x00, 0x00.
- i_rx_ready held 0, three words 0x11/0x22/0x33 -> o_rx_overrun pulses twice; o_rx_data=0x33; valid held until ready.
- CSn released after 5 bits, then a full word 0x7E -> no o_rx_valid for the partial word; next o_rx_data=0x7E; MISO_OE drops within SYNC_STAGES+1 cycles of the CS rise.
- i_rst_n asserted mid-word -> all outputs reset immediately; next full transfer of 0xC3 received correctly; DATA_W=16 variant with 0xBEEF passes.
